// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Moves the sprite layer once per video frame. The direction buttons are
//   sampled at the falling edge of vertical sync; a clamped, hold-to-accelerate
//   step is computed and the new position is published only at that frame
//   boundary so the pixel colour logic never sees a mid-frame change.
// Ports
//   clk_pix    pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   vs         vertical sync (active low, clk_pix domain)
//   enable     1 = frame updates allowed, 0 = position frozen
//   btn_up/btn_down/btn_left/btn_right  asynchronous direction buttons
//   pos_x/pos_y committed sprite position
//   frame_upd  one-cycle pulse when the position is (re)committed
//   busy       high while an update sequence is in progress
module sprite_motion_ctrl #(
  parameter int unsigned POS_W       = 11,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 300,
  parameter int unsigned Y_MIN       = 0,
  parameter int unsigned Y_MAX       = 420,
  parameter int unsigned X_INIT      = 150,
  parameter int unsigned Y_INIT      = 200,
  parameter int unsigned STEP        = 1,
  parameter int unsigned FAST_STEP   = 4,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             vs,
  input  logic             enable,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             frame_upd,
  output logic             busy
);

  localparam int unsigned EW   = POS_W + 1;
  localparam int unsigned HC_W = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CALC, COMMIT} state_t;

  state_t           state_q, state_d;
  logic             vs_d;
  logic [3:0]       btn_s1, btn_s2;      // {up, down, left, right}
  logic [3:0]       dir_q, prev_dir_q;
  logic [HC_W-1:0]  hold_cnt_q, hold_nxt_c;
  logic [POS_W-1:0] nx_q, ny_q, nx_c, ny_c;
  logic [EW-1:0]    step_c;
  logic             frame_edge_c;
  logic             sample_c, calc_c, commit_c, clr_hold_c;

  assign frame_edge_c = vs_d & ~vs;

  // Clamped single-axis move in POS_W+1 bits; opposing buttons cancel.
  function automatic logic [POS_W-1:0] move_axis(
    input logic [POS_W-1:0] pos, input logic inc, input logic dec,
    input logic [EW-1:0] step, input logic [EW-1:0] lo, input logic [EW-1:0] hi);
    logic [EW-1:0] p, r;
    p = {1'b0, pos};
    r = p;
    if (inc && !dec) begin
      r = p + step;
      if (r > hi) r = hi;
    end else if (dec && !inc) begin
      r = (p < lo + step) ? lo : p - step;
    end
    return POS_W'(r);
  endfunction

  // Input capture: vs edge register and 2-flop button synchroniser.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      vs_d   <= 1'b1;
      btn_s1 <= 4'b0;
      btn_s2 <= 4'b0;
    end else begin
      vs_d   <= vs;
      btn_s1 <= {btn_up, btn_down, btn_left, btn_right};
      btn_s2 <= btn_s1;
    end
  end

  // State register.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; frame edges outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_edge_c && enable) state_d = SAMPLE;
      SAMPLE:  state_d = CALC;
      CALC:    state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes decoded from the state.
  always_comb begin
    sample_c   = 1'b0;
    calc_c     = 1'b0;
    commit_c   = 1'b0;
    clr_hold_c = 1'b0;
    case (state_q)
      IDLE:    clr_hold_c = frame_edge_c & ~enable;
      SAMPLE:  sample_c   = 1'b1;
      CALC:    calc_c     = 1'b1;
      COMMIT:  commit_c   = 1'b1;
      default: ;
    endcase
  end

  // Step size and next position/hold count, using hold_cnt as held on CALC entry.
  always_comb begin
    step_c = (hold_cnt_q == HC_W'(HOLD_FRAMES)) ? EW'(FAST_STEP) : EW'(STEP);
    nx_c   = move_axis(pos_x, dir_q[0], dir_q[1], step_c, EW'(X_MIN), EW'(X_MAX));
    ny_c   = move_axis(pos_y, dir_q[2], dir_q[3], step_c, EW'(Y_MIN), EW'(Y_MAX));
    if ((dir_q != 4'b0) && (dir_q == prev_dir_q))
      hold_nxt_c = (hold_cnt_q == HC_W'(HOLD_FRAMES)) ? hold_cnt_q : hold_cnt_q + HC_W'(1);
    else
      hold_nxt_c = '0;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= 4'b0;
      prev_dir_q <= 4'b0;
      hold_cnt_q <= '0;
      nx_q       <= POS_W'(X_INIT);
      ny_q       <= POS_W'(Y_INIT);
      pos_x      <= POS_W'(X_INIT);
      pos_y      <= POS_W'(Y_INIT);
      frame_upd  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (sample_c) dir_q <= btn_s2;
      if (calc_c) begin
        nx_q       <= nx_c;
        ny_q       <= ny_c;
        hold_cnt_q <= hold_nxt_c;
        prev_dir_q <= dir_q;
      end else if (clr_hold_c) begin
        hold_cnt_q <= '0;
      end
      if (commit_c) begin
        pos_x <= nx_q;
        pos_y <= ny_q;
      end
      frame_upd <= commit_c;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: frame-level reference model plus directed
// literal checks for reset, latency, acceleration, clamping, conflicts, enable.
module tb_sprite_motion_ctrl;

  logic        clk_pix = 1'b0;
  logic        rst_n   = 1'b0;
  logic        vs      = 1'b1;
  logic        enable  = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [10:0] pos_x, pos_y;
  logic        frame_upd, busy;

  int n_checks = 0;
  int n_pass   = 0;

  sprite_motion_ctrl dut (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .vs       (vs),
    .enable   (enable),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .frame_upd(frame_upd),
    .busy     (busy)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: one update per accepted frame, visible 3 clocks later.
  int         m_x, m_y, m_hold, m_cnt, p_x, p_y;
  logic [3:0] m_prev;
  logic       m_vsp, m_fu;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic m_reset;
    m_x = 150; m_y = 200; m_hold = 0; m_prev = 4'b0;
    m_cnt = 0; m_vsp = 1'b1; m_fu = 1'b0; p_x = 150; p_y = 200;
  endtask

  task automatic m_step;
    logic [3:0] d;
    int st, dx, dy;
    bit idle;
    idle = (m_cnt == 0);
    m_fu = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_x = p_x; m_y = p_y; m_fu = 1'b1;
      end
    end
    if (idle && m_vsp && !vs) begin
      if (enable) begin
        d  = {btn_up, btn_down, btn_left, btn_right};
        st = (m_hold == 30) ? 4 : 1;
        dx = (d[0] && !d[1]) ? st : (d[1] && !d[0]) ? -st : 0;
        dy = (d[2] && !d[3]) ? st : (d[3] && !d[2]) ? -st : 0;
        p_x = clamp(m_x + dx, 0, 300);
        p_y = clamp(m_y + dy, 0, 420);
        m_hold = (d != 4'b0 && d == m_prev) ? ((m_hold < 30) ? m_hold + 1 : 30) : 0;
        m_prev = d;
        m_cnt  = 3;
      end else begin
        m_hold = 0;
      end
    end
    m_vsp = vs;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_pix or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_pix) begin
    if (rst_n) begin
      check("pos_x", int'(pos_x), m_x);
      check("pos_y", int'(pos_y), m_y);
      check("frame_upd", int'(frame_upd), int'(m_fu));
      check("busy", int'(busy), (m_cnt > 0) ? 1 : 0);
    end
  end

  // One 13-cycle frame; buttons/enable settle well before the vs falling edge.
  task automatic frame(input logic [3:0] b, input logic en, input logic glitch);
    {btn_up, btn_down, btn_left, btn_right} = b;
    enable = en;
    repeat (5) @(posedge clk_pix);
    #1 vs = 1'b0;
    @(posedge clk_pix);
    #1 if (glitch) enable = 1'b0;
    @(posedge clk_pix);
    #1 vs = 1'b1;
    repeat (6) @(posedge clk_pix);
    #1;
  endtask

  logic [3:0] cur;
  logic       en_r, gl_r;

  initial begin
    repeat (3) @(posedge clk_pix);
    #1 rst_n = 1'b1;
    check("reset_pos_x", int'(pos_x), 150);
    check("reset_pos_y", int'(pos_y), 200);
    check("reset_frame_upd", int'(frame_upd), 0);
    check("reset_busy", int'(busy), 0);

    // Latency: commit and pulse appear exactly 3 clocks after the edge is registered.
    btn_right = 1'b1;
    enable    = 1'b1;
    repeat (4) @(posedge clk_pix);
    #1 vs = 1'b0;
    @(posedge clk_pix); @(negedge clk_pix);
    check("lat_busy_k", int'(busy), 1);
    check("lat_x_k", int'(pos_x), 150);
    @(posedge clk_pix); @(negedge clk_pix);
    check("lat_x_k1", int'(pos_x), 150);
    @(posedge clk_pix); @(negedge clk_pix);
    check("lat_x_k2", int'(pos_x), 150);
    check("lat_fu_k2", int'(frame_upd), 0);
    @(posedge clk_pix); @(negedge clk_pix);
    check("lat_x_k3", int'(pos_x), 151);
    check("lat_fu_k3", int'(frame_upd), 1);
    @(posedge clk_pix);
    #1 vs = 1'b1;
    repeat (6) @(posedge clk_pix);
    #1;

    // Acceleration: the first press frame has no matching predecessor, so
    // hold_cnt reaches 30 on entry to frame 32: 31 slow steps then 4 fast.
    for (int i = 0; i < 34; i++) frame(4'b0001, 1'b1, 1'b0);
    check("accel_x35", int'(pos_x), 197);

    // Enable low: frozen, and hold count cleared so the next step is slow.
    for (int i = 0; i < 5; i++) frame(4'b0001, 1'b0, 1'b0);
    check("disabled_x", int'(pos_x), 197);
    frame(4'b0001, 1'b1, 1'b0);
    check("reenable_slow_x", int'(pos_x), 198);

    // Clamp at the left edge with fast stepping, no wrap.
    for (int i = 0; i < 100; i++) frame(4'b0010, 1'b1, 1'b0);
    check("clamp_x0", int'(pos_x), 0);
    for (int i = 0; i < 3; i++) frame(4'b0010, 1'b1, 1'b0);
    check("clamp_x0_hold", int'(pos_x), 0);
    check("clamp_y", int'(pos_y), 200);

    // Asynchronous reset in the middle of CALC discards the update.
    btn_left = 1'b0; btn_down = 1'b1;
    repeat (4) @(posedge clk_pix);
    #1 vs = 1'b0;
    @(posedge clk_pix);
    @(posedge clk_pix);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_x", int'(pos_x), 150);
    check("async_rst_y", int'(pos_y), 200);
    check("async_rst_fu", int'(frame_upd), 0);
    check("async_rst_busy", int'(busy), 0);
    vs = 1'b1;
    repeat (2) @(posedge clk_pix);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk_pix);
    #1;

    // Conflicting buttons: up+down cancel, left still applies.
    frame(4'b1110, 1'b1, 1'b0);
    check("conflict_x", int'(pos_x), 149);
    check("conflict_y", int'(pos_y), 200);
    frame(4'b1110, 1'b1, 1'b0);
    check("conflict_x2", int'(pos_x), 148);

    // Randomised frames with run-length biased directions.
    cur = 4'b0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(7) == 0) cur = 4'($urandom_range(15));
      en_r = ($urandom_range(9) != 0);
      gl_r = ($urandom_range(7) == 0);
      frame(cur, en_r, gl_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
